hazard_detect: RTL and testbench

Producer of the data-hazard indications consumed by the pipeline's operand-forwarding unit. Tracks the destination registers of the two older in-flight instructions (EX and MEM slots) in a shadow pipeline, compares them against the source registers of the instruction in ID, and emits registered hazard flags and source-select codes. Also detects load-use hazards, raises a one-cycle stall, and inserts a bubble into the shadow pipeline.

---
 rtl/hazard_detect_pkg.sv | 63 ++++++
 rtl/hazard_cmp.sv | 21 ++
 rtl/hazard_detect.sv | 141 ++++++++++++++
 tb/tb_hazard_detect.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_detect_pkg.sv
// Shared definitions for the hazard detector: RV32I major opcodes, hazard
// source-select codes used by the forwarding unit, the shadow-pipeline entry
// type and the opcode decode helpers.
package hazard_detect_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Source-select codes consumed by the forwarding unit
    localparam logic [2:0] HZ_NONE    = 3'd0;
    localparam logic [2:0] HZ_EX_RS1  = 3'd1;
    localparam logic [2:0] HZ_EX_RS2  = 3'd2;
    localparam logic [2:0] HZ_MEM_RS1 = 3'd3;
    localparam logic [2:0] HZ_MEM_RS2 = 3'd4;

    // One slot of the shadow pipeline
    typedef struct packed {
        logic       wen;
        logic [4:0] rd;
        logic       is_load;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_BUBBLE = '{wen: 1'b0, rd: 5'd0, is_load: 1'b0};

    // Every opcode reads rs1 except the upper-immediate forms and JAL.
    function automatic logic op_reads_rs1(input logic [6:0] op);
        logic r;
        r = 1'b1;
        if (op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL) begin
            r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic op_reads_rs2(input logic [6:0] op);
        logic r;
        r = 1'b0;
        if (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH) begin
            r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic op_writes_rd(input logic [6:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one shadow-pipeline entry against the two source registers of the
// instruction in ID. x0 never matches.
module hazard_cmp
    import hazard_detect_pkg::*;
(
    input  shadow_entry_t entry_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic          use_rs1_i,
    input  logic          use_rs2_i,
    output logic          match_rs1_o,
    output logic          match_rs2_o
);

    // Match only live writers against operands the ID instruction really reads
    always_comb begin
        match_rs1_o = entry_i.wen && use_rs1_i && (rs1_i != 5'd0) && (entry_i.rd == rs1_i);
        match_rs2_o = entry_i.wen && use_rs2_i && (rs2_i != 5'd0) && (entry_i.rd == rs2_i);
    end

endmodule

// File: rtl/hazard_detect.sv
// Data-hazard detector feeding the operand-forwarding unit. Keeps a two-slot
// shadow pipeline (EX, MEM) of destination registers, compares it with the
// sources of the instruction in ID and registers hazard flags/codes for the
// next cycle. Load-use conflicts raise a zero-latency, one-cycle stall and
// push a bubble into the shadow EX slot.
module hazard_detect
    import hazard_detect_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [6:0]  id_op,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        is_hazard1,
    output logic [2:0]  hazard_reg1,
    output logic        is_hazard2,
    output logic [2:0]  hazard_reg2,
    output logic        stall,
    output logic [15:0] stall_count
);

    shadow_entry_t ex_q, ex_d;
    shadow_entry_t mem_q, mem_d;
    shadow_entry_t id_entry;

    logic        use_rs1, use_rs2;
    logic        ex_match_rs1, ex_match_rs2;
    logic        mem_match_rs1, mem_match_rs2;
    logic        load_use;

    logic        hz1_q, hz1_d;
    logic [2:0]  code1_q, code1_d;
    logic        hz2_q, hz2_d;
    logic [2:0]  code2_q, code2_d;
    logic [15:0] count_q, count_d;

    // Decode the ID instruction into operand-use flags and a shadow entry
    always_comb begin
        use_rs1          = id_valid && op_reads_rs1(id_op);
        use_rs2          = id_valid && op_reads_rs2(id_op);
        id_entry         = SHADOW_BUBBLE;
        id_entry.wen     = op_writes_rd(id_op) && (id_rd != 5'd0);
        id_entry.rd      = id_rd;
        id_entry.is_load = (id_op == OPC_LOAD);
    end

    hazard_cmp u_cmp_ex (
        .entry_i     (ex_q),
        .rs1_i       (id_rs1),
        .rs2_i       (id_rs2),
        .use_rs1_i   (use_rs1),
        .use_rs2_i   (use_rs2),
        .match_rs1_o (ex_match_rs1),
        .match_rs2_o (ex_match_rs2)
    );

    hazard_cmp u_cmp_mem (
        .entry_i     (mem_q),
        .rs1_i       (id_rs1),
        .rs2_i       (id_rs2),
        .use_rs1_i   (use_rs1),
        .use_rs2_i   (use_rs2),
        .match_rs1_o (mem_match_rs1),
        .match_rs2_o (mem_match_rs2)
    );

    // Load-use: a load in EX whose result the ID instruction needs; a flush wins
    always_comb begin
        load_use = ex_q.is_load && (ex_match_rs1 || ex_match_rs2);
        stall    = load_use && !flush;
    end

    // Next state of the shadow pipeline, hazard registers and stall counter
    always_comb begin
        mem_d   = ex_q;
        ex_d    = id_entry;
        hz1_d   = 1'b0;
        code1_d = HZ_NONE;
        hz2_d   = 1'b0;
        code2_d = HZ_NONE;
        count_d = count_q;

        if (stall || flush || !id_valid) begin
            ex_d = SHADOW_BUBBLE;
        end

        // Stalled or killed instructions do not advance, so report nothing
        if (id_valid && !stall && !flush) begin
            if (ex_match_rs1) begin
                hz1_d   = 1'b1;
                code1_d = HZ_EX_RS1;
            end else if (ex_match_rs2) begin
                hz1_d   = 1'b1;
                code1_d = HZ_EX_RS2;
            end

            if (mem_match_rs1) begin
                hz2_d   = 1'b1;
                code2_d = HZ_MEM_RS1;
            end else if (mem_match_rs2) begin
                hz2_d   = 1'b1;
                code2_d = HZ_MEM_RS2;
            end
        end

        if (stall && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= SHADOW_BUBBLE;
            mem_q   <= SHADOW_BUBBLE;
            hz1_q   <= 1'b0;
            code1_q <= HZ_NONE;
            hz2_q   <= 1'b0;
            code2_q <= HZ_NONE;
            count_q <= 16'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            hz1_q   <= hz1_d;
            code1_q <= code1_d;
            hz2_q   <= hz2_d;
            code2_q <= code2_d;
            count_q <= count_d;
        end
    end

    assign is_hazard1  = hz1_q;
    assign hazard_reg1 = code1_q;
    assign is_hazard2  = hz2_q;
    assign hazard_reg2 = code2_q;
    assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: short instruction sequences with
// hand-computed hazard flags, codes, stall and stall counter values.
module tb_hazard_detect;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;
    logic        is_hazard1, is_hazard2, stall;
    logic [2:0]  hazard_reg1, hazard_reg2;
    logic [15:0] stall_count;

    int n_tests;
    int n_fail;
    logic stall_s;

    hazard_detect dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .flush       (flush),
        .is_hazard1  (is_hazard1),
        .hazard_reg1 (hazard_reg1),
        .is_hazard2  (is_hazard2),
        .hazard_reg2 (hazard_reg2),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one ID instruction for a cycle; stall is sampled mid-cycle and
    // the registered flags for this instruction are visible on return.
    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic fl);
        id_valid = v;
        id_op    = op;
        id_rs1   = r1;
        id_rs2   = r2;
        id_rd    = rd;
        flush    = fl;
        @(negedge clk);
        stall_s = stall;
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, OP_OP, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic check_flags(input string tag, input logic h1, input logic [2:0] c1,
                               input logic h2, input logic [2:0] c2);
        check({tag, ".hz1"}, {31'd0, is_hazard1}, {31'd0, h1});
        check({tag, ".reg1"}, {29'd0, hazard_reg1}, {29'd0, c1});
        check({tag, ".hz2"}, {31'd0, is_hazard2}, {31'd0, h2});
        check({tag, ".reg2"}, {29'd0, hazard_reg2}, {29'd0, c2});
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        stall_s  = 1'b0;
        reset    = 1'b0;
        id_valid = 1'b0;
        id_op    = 7'd0;
        id_rs1   = 5'd0;
        id_rs2   = 5'd0;
        id_rd    = 5'd0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        check_flags("reset", 1'b0, 3'd0, 1'b0, 3'd0);
        check("reset.stall", {31'd0, stall}, 32'd0);
        check("reset.count", {16'd0, stall_count}, 32'd0);
        @(posedge clk);
        #1;

        // add x5,x1,x2 ; add x6,x5,x3
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd5, 1'b0);
        check_flags("ex_fwd.prod", 1'b0, 3'd0, 1'b0, 3'd0);
        issue(1'b1, OP_OP, 5'd5, 5'd3, 5'd6, 1'b0);
        check_flags("ex_fwd", 1'b1, 3'd1, 1'b0, 3'd0);
        check("ex_fwd.stall", {31'd0, stall_s}, 32'd0);
        idle(2);

        // add x7,x1,x2 ; nop ; sub x8,x9,x7
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd7, 1'b0);
        issue(1'b1, OP_OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(1'b1, OP_OP, 5'd9, 5'd7, 5'd8, 1'b0);
        check_flags("mem_fwd", 1'b0, 3'd0, 1'b1, 3'd4);
        idle(2);

        // lw x10,0(x1) ; add x11,x10,x0 (stalls once, then forwards from MEM)
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd10, 1'b0);
        issue(1'b1, OP_OP, 5'd10, 5'd0, 5'd11, 1'b0);
        check("lu.stall", {31'd0, stall_s}, 32'd1);
        check_flags("lu.stallcyc", 1'b0, 3'd0, 1'b0, 3'd0);
        issue(1'b1, OP_OP, 5'd10, 5'd0, 5'd11, 1'b0);
        check("lu.nostall", {31'd0, stall_s}, 32'd0);
        check_flags("lu.held", 1'b0, 3'd0, 1'b1, 3'd3);
        check("lu.count", {16'd0, stall_count}, 32'd1);
        idle(2);

        // add x3 ; add x4 ; add x5,x3,x4 -> EX rs2 and MEM rs1 together
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd4, 1'b0);
        issue(1'b1, OP_OP, 5'd3, 5'd4, 5'd5, 1'b0);
        check_flags("both", 1'b1, 3'd2, 1'b1, 3'd3);
        idle(2);

        // add x3 ; add x4 ; add x5,x4,x4 -> rs1 code wins
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd4, 1'b0);
        issue(1'b1, OP_OP, 5'd4, 5'd4, 5'd5, 1'b0);
        check_flags("same_src", 1'b1, 3'd1, 1'b0, 3'd0);
        idle(2);

        // addi x0,x1,1 ; add x9,x0,x0 -> x0 never matches
        issue(1'b1, OP_OP_IMM, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(1'b1, OP_OP, 5'd0, 5'd0, 5'd9, 1'b0);
        check_flags("x0", 1'b0, 3'd0, 1'b0, 3'd0);
        idle(2);

        // add x12 ; lui x13 with rs1/rs2 fields = 12 -> LUI reads nothing
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd12, 1'b0);
        issue(1'b1, OP_LUI, 5'd12, 5'd12, 5'd13, 1'b0);
        check_flags("lui", 1'b0, 3'd0, 1'b0, 3'd0);
        idle(2);

        // jal x1 ; beq x2,x1 -> EX rs2
        issue(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
        issue(1'b1, OP_BRANCH, 5'd2, 5'd1, 5'd0, 1'b0);
        check_flags("jal_br", 1'b1, 3'd2, 1'b0, 3'd0);
        idle(2);

        // lw x14 ; add x15,x14,x0 with flush -> no stall, no flags
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd14, 1'b0);
        issue(1'b1, OP_OP, 5'd14, 5'd0, 5'd15, 1'b1);
        check("flush.stall", {31'd0, stall_s}, 32'd0);
        check_flags("flush", 1'b0, 3'd0, 1'b0, 3'd0);
        check("flush.count", {16'd0, stall_count}, 32'd1);
        idle(2);

        // add x20 ; lw x22,0(x20) ; then reset while a load-use is pending
        issue(1'b1, OP_OP, 5'd1, 5'd2, 5'd20, 1'b0);
        issue(1'b1, OP_LOAD, 5'd20, 5'd0, 5'd22, 1'b0);
        check_flags("prerst", 1'b1, 3'd1, 1'b0, 3'd0);
        id_valid = 1'b1;
        id_op    = OP_OP;
        id_rs1   = 5'd22;
        id_rs2   = 5'd0;
        id_rd    = 5'd23;
        #1;
        check("prerst.stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check_flags("rst_async", 1'b0, 3'd0, 1'b0, 3'd0);
        check("rst_async.stall", {31'd0, stall}, 32'd0);
        check("rst_async.count", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, OP_OP, 5'd22, 5'd0, 5'd24, 1'b0);
        check("postrst.stall", {31'd0, stall_s}, 32'd0);
        check_flags("postrst", 1'b0, 3'd0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
